// File: rtl/mem_pkg.sv
// Shared types and constants for the per-bank memory scheduler slice.
// Holds the scheduler FSM state enum, operation and id encodings, the
// request metadata payload and an index-width helper.
package mem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned OP_W   = 3;
    localparam int unsigned ID_W   = 2;

    // Bank command operations
    localparam logic [OP_W-1:0] OP_LD    = 3'd0;
    localparam logic [OP_W-1:0] OP_ST    = 3'd1;
    localparam logic [OP_W-1:0] OP_FLUSH = 3'd2;

    // Source / destination ids
    localparam logic [ID_W-1:0] ID_CORE0 = 2'd0;
    localparam logic [ID_W-1:0] ID_CORE1 = 2'd1;
    localparam logic [ID_W-1:0] ID_DMA   = 2'd2;
    localparam logic [ID_W-1:0] ID_MEM   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_GAP
    } sched_state_e;

    // Request fields latched at grant time (line data is kept separately)
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [OP_W-1:0]   op;
        logic [ID_W-1:0]   src;
        logic [ID_W-1:0]   dest;
        logic              flush;
    } req_meta_t;

    // Bits needed to index n items (at least 1)
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bank_sched_if.sv
// Bundle of queue-side, bank-side and output-queue-side signals of one
// bank scheduler.
//   slave  : the scheduler's view (queue heads / bank response / full in)
//   master : the environment's view (queue heads / bank response / full out)
interface mem_bank_sched_if
    import mem_pkg::*;
#(
    parameter int unsigned CL_SIZE = 128,
    parameter int unsigned Q_WIDTH = 2
);
    // Queue heads
    logic [Q_WIDTH*ADDR_W-1:0] addr_in;
    logic [CL_SIZE-1:0]        data_in;
    logic [Q_WIDTH*OP_W-1:0]   operation_in;
    logic [Q_WIDTH-1:0]        valid_in;
    logic [Q_WIDTH*ID_W-1:0]   src_in;
    logic [Q_WIDTH*ID_W-1:0]   dest_in;
    logic [Q_WIDTH-1:0]        is_flush_in;
    logic [Q_WIDTH-1:0]        dealloc;
    // Bank command / completion
    logic                      bank_req_valid;
    logic [ADDR_W-1:0]         bank_addr;
    logic [OP_W-1:0]           bank_operation;
    logic [CL_SIZE-1:0]        bank_data;
    logic                      bank_rsp_valid;
    logic [CL_SIZE-1:0]        bank_rsp_data;
    // Output queue
    logic [ADDR_W-1:0]         addr_out;
    logic [CL_SIZE-1:0]        data_out;
    logic [OP_W-1:0]           operation_out;
    logic [ID_W-1:0]           src_out;
    logic [ID_W-1:0]           dest_out;
    logic                      is_flush_out;
    logic                      alloc_out;
    logic                      full_in;
    // Status
    logic                      busy;
    logic                      err_out;

    modport slave (
        input  addr_in, data_in, operation_in, valid_in, src_in, dest_in, is_flush_in,
        output dealloc,
        output bank_req_valid, bank_addr, bank_operation, bank_data,
        input  bank_rsp_valid, bank_rsp_data,
        output addr_out, data_out, operation_out, src_out, dest_out, is_flush_out, alloc_out,
        input  full_in,
        output busy, err_out
    );

    modport master (
        output addr_in, data_in, operation_in, valid_in, src_in, dest_in, is_flush_in,
        input  dealloc,
        input  bank_req_valid, bank_addr, bank_operation, bank_data,
        output bank_rsp_valid, bank_rsp_data,
        input  addr_out, data_out, operation_out, src_out, dest_out, is_flush_out, alloc_out,
        output full_in,
        input  busy, err_out
    );

endinterface

// File: rtl/mem_bank_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester searching upward
// from ptr with wrap-around.
//   valid : per-requester request
//   ptr   : highest-priority requester index
//   grant : one-hot grant (zero when nothing valid)
//   idx   : index of the granted requester
//   found : any requester valid
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] cand;

    // Rotating priority search
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bank_sched.sv
// Per-bank request scheduler: grants queue heads round-robin, issues one
// bank command at a time, waits for completion (with watchdog), hands the
// response to the output queue and enforces a recovery gap.
//   clk, rst : clock, synchronous active-high reset
//   bus      : queue heads + dealloc, bank command/response, output queue
//              push + full, busy and sticky timeout error
module mem_bank_sched
    import mem_pkg::*;
#(
    parameter int unsigned CL_SIZE  = 128,
    parameter int unsigned Q_WIDTH  = 2,
    parameter int unsigned BANK_GAP = 2,
    parameter int unsigned TIMEOUT  = 64,
    parameter int unsigned CNT_W    = 8
) (
    input  logic          clk,
    input  logic          rst,
    mem_bank_sched_if.slave bus
);

    localparam int unsigned PTR_W  = idx_width(Q_WIDTH);
    localparam int unsigned DATA_Q = Q_WIDTH - 1;

    sched_state_e     state;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] gnt_idx;
    logic [Q_WIDTH-1:0] gnt_oh;
    logic             gnt_found;
    logic [CNT_W-1:0] cnt;
    req_meta_t        req;
    req_meta_t        head;

    rr_arbiter #(
        .N  (Q_WIDTH),
        .IW (PTR_W)
    ) u_arb (
        .valid (bus.valid_in),
        .ptr   (ptr),
        .grant (gnt_oh),
        .idx   (gnt_idx),
        .found (gnt_found)
    );

    // Fields of the queue currently winning arbitration
    always_comb begin
        head       = '0;
        head.addr  = bus.addr_in[32'(gnt_idx)*ADDR_W +: ADDR_W];
        head.op    = bus.operation_in[32'(gnt_idx)*OP_W +: OP_W];
        head.src   = bus.src_in[32'(gnt_idx)*ID_W +: ID_W];
        head.dest  = bus.dest_in[32'(gnt_idx)*ID_W +: ID_W];
        head.flush = bus.is_flush_in[gnt_idx];
    end

    // Pop and push strobes are same-cycle; masked during reset so nothing
    // is popped or pushed while the transaction is being abandoned.
    assign bus.dealloc   = (!rst && state == ST_IDLE && gnt_found) ? gnt_oh : '0;
    assign bus.alloc_out = !rst && state == ST_RESP && !bus.full_in;
    assign bus.busy      = (state != ST_IDLE);

    // Sequencer and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            ptr                <= '0;
            cnt                <= '0;
            req                <= '0;
            bus.bank_req_valid <= 1'b0;
            bus.bank_addr      <= '0;
            bus.bank_operation <= '0;
            bus.bank_data      <= '0;
            bus.addr_out       <= '0;
            bus.data_out       <= '0;
            bus.operation_out  <= '0;
            bus.src_out        <= '0;
            bus.dest_out       <= '0;
            bus.is_flush_out   <= 1'b0;
            bus.err_out        <= 1'b0;
        end else begin
            bus.bank_req_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_found) begin
                        req                <= head;
                        bus.bank_addr      <= head.addr;
                        bus.bank_operation <= head.op;
                        // Only the data queue carries a line
                        bus.bank_data      <= (32'(gnt_idx) == DATA_Q) ? bus.data_in : '0;
                        ptr                <= PTR_W'((32'(gnt_idx) + 32'd1) % Q_WIDTH);
                        bus.bank_req_valid <= 1'b1;
                        state              <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.bank_rsp_valid) begin
                        bus.data_out      <= bus.bank_rsp_data;
                        bus.addr_out      <= req.addr;
                        bus.operation_out <= req.op;
                        bus.src_out       <= req.dest;
                        bus.dest_out      <= req.src;
                        bus.is_flush_out  <= req.flush;
                        state             <= ST_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        // Watchdog: deliver an empty line and flag it
                        bus.err_out       <= 1'b1;
                        bus.data_out      <= '0;
                        bus.addr_out      <= req.addr;
                        bus.operation_out <= req.op;
                        bus.src_out       <= req.dest;
                        bus.dest_out      <= req.src;
                        bus.is_flush_out  <= req.flush;
                        state             <= ST_RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (!bus.full_in) begin
                        if (BANK_GAP == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            cnt   <= CNT_W'(BANK_GAP - 1);
                            state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bank_sched.sv
// Self-checking bench for mem_bank_sched: a vector table of whole
// transactions, directed reset-in-WAIT sequence, then randomized traffic
// checked against a transaction/timestamp reference model.
module tb_mem_bank_sched;
    import mem_pkg::*;

    localparam int unsigned CL  = 128;
    localparam int unsigned QW  = 2;
    localparam int          GAP = 2;
    localparam int          TO  = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_bank_sched_if #(.CL_SIZE(CL), .Q_WIDTH(QW)) bus ();

    mem_bank_sched #(
        .CL_SIZE  (CL),
        .Q_WIDTH  (QW),
        .BANK_GAP (GAP),
        .TIMEOUT  (TO),
        .CNT_W    (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic exp_err = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector helpers ----------------
    function automatic logic [31:0] vaddr(input int k, input int q);
        return 32'h0000_1040 + 32'(k) * 32'h40 + 32'(q) * 32'h10;
    endfunction
    function automatic logic [2:0] vop(input int k, input int q);
        if (q == 0) return OP_LD;
        return (k % 2 == 1) ? OP_FLUSH : OP_ST;
    endfunction
    function automatic logic [1:0] vsrc(input int q);
        return (q == 0) ? ID_CORE0 : ID_DMA;
    endfunction
    function automatic logic vflush(input int k, input int q);
        return (q == 1) && (k % 2 == 1);
    endfunction
    function automatic logic [127:0] vdata(input int k);
        return {4{32'hD000_0000 + 32'(k)}};
    endfunction
    function automatic logic [127:0] vrsp(input int k);
        return {4{32'hB000_0000 + 32'(k)}};
    endfunction

    task automatic clear_inputs();
        bus.addr_in        = '0;
        bus.data_in        = '0;
        bus.operation_in   = '0;
        bus.valid_in       = '0;
        bus.src_in         = '0;
        bus.dest_in        = '0;
        bus.is_flush_in    = '0;
        bus.bank_rsp_valid = 1'b0;
        bus.bank_rsp_data  = '0;
        bus.full_in        = 1'b0;
    endtask

    task automatic drive_vec(input int k, input logic [1:0] v);
        for (int q = 0; q < QW; q++) begin
            bus.addr_in[q*32 +: 32]     = vaddr(k, q);
            bus.operation_in[q*3 +: 3]  = vop(k, q);
            bus.src_in[q*2 +: 2]        = vsrc(q);
            bus.dest_in[q*2 +: 2]       = ID_MEM;
            bus.is_flush_in[q]          = vflush(k, q);
        end
        bus.data_in  = vdata(k);
        bus.valid_in = v;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_dealloc"}, bus.dealloc, '0);
        chk({tag, "_req_valid"}, bus.bank_req_valid, '0);
        chk({tag, "_bank_addr"}, bus.bank_addr, '0);
        chk({tag, "_bank_op"}, bus.bank_operation, '0);
        chk({tag, "_bank_data"}, bus.bank_data, '0);
        chk({tag, "_addr_out"}, bus.addr_out, '0);
        chk({tag, "_data_out"}, bus.data_out, '0);
        chk({tag, "_misc_out"}, {bus.operation_out, bus.src_out, bus.dest_out, bus.is_flush_out}, '0);
        chk({tag, "_alloc"}, bus.alloc_out, '0);
        chk({tag, "_busy"}, bus.busy, '0);
        chk({tag, "_err"}, bus.err_out, '0);
    endtask

    typedef struct {
        logic [1:0] valid;
        int         lat;        // bank latency after strobe, 0 = never responds
        int         full_cyc;   // cycles full_in held high in RESP
        logic [1:0] exp_dealloc;
    } vec_t;

    vec_t vecs [8];

    // One whole transaction starting in IDLE, ending back in IDLE
    task automatic run_vec(input int k, input vec_t v);
        int g;
        int nw;
        logic [127:0] exp_d;
        drive_vec(k, v.valid);
        #1;
        chk("vec_dealloc", bus.dealloc, v.exp_dealloc);
        chk("vec_idle_busy", bus.busy, 1'b0);
        g = v.exp_dealloc[1] ? 1 : 0;
        tick();
        bus.valid_in = '0;
        #1;
        chk("vec_strobe", bus.bank_req_valid, 1'b1);
        chk("vec_bank_addr", bus.bank_addr, vaddr(k, g));
        chk("vec_bank_op", bus.bank_operation, vop(k, g));
        chk("vec_bank_data", bus.bank_data, (g == 1) ? vdata(k) : 128'd0);
        nw = (v.lat == 0) ? TO + 1 : v.lat + 1;
        for (int j = 1; j < nw; j++) begin
            tick();
            if (v.lat != 0 && j == v.lat) begin
                bus.bank_rsp_valid = 1'b1;
                bus.bank_rsp_data  = vrsp(k);
            end
            #1;
            chk("vec_wait_strobe", bus.bank_req_valid, 1'b0);
            chk("vec_wait_alloc", bus.alloc_out, 1'b0);
            if (j == nw - 1) chk("vec_wait_err", bus.err_out, exp_err);
        end
        tick();
        bus.bank_rsp_valid = 1'b0;
        bus.bank_rsp_data  = '0;
        if (v.lat == 0) exp_err = 1'b1;
        exp_d = (v.lat == 0) ? 128'd0 : vrsp(k);
        for (int j = 0; j < v.full_cyc; j++) begin
            bus.full_in = 1'b1;
            #1;
            chk("vec_full_alloc", bus.alloc_out, 1'b0);
            chk("vec_full_data", bus.data_out, exp_d);
            chk("vec_full_addr", bus.addr_out, vaddr(k, g));
            tick();
        end
        bus.full_in = 1'b0;
        #1;
        chk("vec_alloc", bus.alloc_out, 1'b1);
        chk("vec_data_out", bus.data_out, exp_d);
        chk("vec_addr_out", bus.addr_out, vaddr(k, g));
        chk("vec_op_out", bus.operation_out, vop(k, g));
        chk("vec_src_out", bus.src_out, ID_MEM);
        chk("vec_dest_out", bus.dest_out, vsrc(g));
        chk("vec_flush_out", bus.is_flush_out, vflush(k, g));
        chk("vec_err", bus.err_out, exp_err);
        tick();
        // Recovery gap: requests pending but nothing granted
        for (int j = 0; j < GAP; j++) begin
            bus.valid_in = 2'b11;
            #1;
            chk("vec_gap_busy", bus.busy, 1'b1);
            chk("vec_gap_dealloc", bus.dealloc, '0);
            chk("vec_gap_alloc", bus.alloc_out, 1'b0);
            tick();
        end
    endtask

    // ---------------- random reference model ----------------
    typedef struct {
        logic [31:0]  addr;
        logic [2:0]   op;
        logic [1:0]   src;
        logic [1:0]   dest;
        logic         flush;
        logic [127:0] data;
    } entry_t;

    task automatic run_random(input int ncyc);
        entry_t qs [QW][$];
        entry_t e;
        entry_t cur;
        int g_cur = 0, grant_c = 0, rsp_c = 0, resp_start = 0, idle_from = 0, m_ptr = 0;
        bit in_txn = 0, alloc_done = 0, tmo = 0, in_wait, m_err = 0, exp_al;
        logic [127:0] rsp_d = '0;
        logic [1:0] exp_dl;
        for (int c = 0; c < ncyc; c++) begin
            if (in_txn && alloc_done && c >= idle_from) in_txn = 0;
            for (int q = 0; q < QW; q++) begin
                if (qs[q].size() < 4 && $urandom_range(0, 3) == 0) begin
                    e.addr  = $urandom;
                    e.op    = 3'($urandom_range(0, 2));
                    e.src   = 2'($urandom);
                    e.dest  = 2'($urandom);
                    e.flush = 1'($urandom);
                    e.data  = {$urandom, $urandom, $urandom, $urandom};
                    qs[q].push_back(e);
                end
                bus.valid_in[q] = (qs[q].size() > 0);
                if (qs[q].size() > 0) begin
                    bus.addr_in[q*32 +: 32]    = qs[q][0].addr;
                    bus.operation_in[q*3 +: 3] = qs[q][0].op;
                    bus.src_in[q*2 +: 2]       = qs[q][0].src;
                    bus.dest_in[q*2 +: 2]      = qs[q][0].dest;
                    bus.is_flush_in[q]         = qs[q][0].flush;
                end
            end
            bus.data_in = (qs[1].size() > 0) ? qs[1][0].data : {$urandom, $urandom, $urandom, $urandom};
            bus.full_in = ($urandom_range(0, 2) == 0);
            in_wait = in_txn && (c > grant_c + 1) && (c < resp_start);
            if (in_txn && !tmo && c == rsp_c) begin
                rsp_d = {$urandom, $urandom, $urandom, $urandom};
                bus.bank_rsp_valid = 1'b1;
                bus.bank_rsp_data  = rsp_d;
            end else if (!in_wait) begin
                // Stray completions outside WAIT must be ignored
                bus.bank_rsp_valid = ($urandom_range(0, 7) == 0);
                bus.bank_rsp_data  = {$urandom, $urandom, $urandom, $urandom};
            end else begin
                bus.bank_rsp_valid = 1'b0;
            end
            #1;
            exp_dl = '0;
            if (!in_txn && c >= idle_from) begin
                for (int k = 0; k < QW; k++) begin
                    int i;
                    i = (m_ptr + k) % QW;
                    if (exp_dl == '0 && qs[i].size() > 0) begin
                        exp_dl[i] = 1'b1;
                        g_cur = i;
                    end
                end
                if (exp_dl != '0) begin
                    cur        = qs[g_cur].pop_front();
                    m_ptr      = (g_cur + 1) % QW;
                    in_txn     = 1;
                    alloc_done = 0;
                    grant_c    = c;
                    tmo        = ($urandom_range(0, 9) == 0);
                    rsp_c      = c + 1 + int'($urandom_range(1, 6));
                    resp_start = tmo ? c + 2 + TO : rsp_c + 1;
                end
            end
            chk("rnd_dealloc", bus.dealloc, exp_dl);
            chk("rnd_req_valid", bus.bank_req_valid, in_txn && c == grant_c + 1);
            if (in_txn && c == grant_c + 1) begin
                chk("rnd_bank_addr", bus.bank_addr, cur.addr);
                chk("rnd_bank_op", bus.bank_operation, cur.op);
                chk("rnd_bank_data", bus.bank_data, (g_cur == 1) ? cur.data : 128'd0);
            end
            if (in_txn && tmo && c == resp_start) m_err = 1;
            exp_al = in_txn && !alloc_done && c >= resp_start && !bus.full_in;
            chk("rnd_alloc", bus.alloc_out, exp_al);
            if (exp_al) begin
                chk("rnd_data_out", bus.data_out, tmo ? 128'd0 : rsp_d);
                chk("rnd_addr_out", bus.addr_out, cur.addr);
                chk("rnd_op_out", bus.operation_out, cur.op);
                chk("rnd_src_out", bus.src_out, cur.dest);
                chk("rnd_dest_out", bus.dest_out, cur.src);
                chk("rnd_flush_out", bus.is_flush_out, cur.flush);
                alloc_done = 1;
                idle_from  = c + 1 + GAP;
            end
            chk("rnd_busy", bus.busy, in_txn && c > grant_c);
            chk("rnd_err", bus.err_out, m_err);
            tick();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        vecs[0] = '{2'b01, 3,  0, 2'b01};
        vecs[1] = '{2'b11, 1,  0, 2'b10};
        vecs[2] = '{2'b11, 2,  0, 2'b01};
        vecs[3] = '{2'b01, 5, 10, 2'b01};
        vecs[4] = '{2'b10, 1,  0, 2'b10};
        vecs[5] = '{2'b10, 4,  0, 2'b10};
        vecs[6] = '{2'b11, 2,  3, 2'b01};
        vecs[7] = '{2'b11, 0,  0, 2'b10};

        // Reset, with requests pending: nothing may be popped
        clear_inputs();
        rst = 1'b1;
        drive_vec(0, 2'b11);
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;

        for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);
        bus.valid_in = '0;

        // Reset during WAIT, then a late bank completion
        drive_vec(9, 2'b01);
        #1;
        chk("rstw_dealloc", bus.dealloc, 2'b01);
        tick();
        bus.valid_in = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        bus.bank_rsp_valid = 1'b1;
        bus.bank_rsp_data  = vrsp(9);
        #1;
        chk_zero("rstw");
        tick();
        bus.bank_rsp_valid = 1'b0;
        bus.bank_rsp_data  = '0;
        #1;
        chk_zero("rstw_late");
        drive_vec(10, 2'b11);
        #1;
        chk("rstw_ptr_grant", bus.dealloc, 2'b01);
        bus.valid_in = '0;
        tick();
        chk("rstw_no_grant", bus.busy, 1'b0);

        run_random(3000);

        clear_inputs();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bank_sched.md
Name: mem_bank_sched

Overview:
Per-bank request scheduler for the DRAM memory subsystem. One instance sits between a bank's input queues (data queue, instr queue) and its dram_bank. It replaces the purely combinational queue arbitration with a sequenced controller:
- round-robin grant across queues, with a dealloc pulse to the granted queue;
- one outstanding bank command at a time, tracked to completion;
- response delivery to the bank's output data queue, honouring its full signal;
- a programmable bank recovery gap and a watchdog timeout.

Parameters:
CL_SIZE, 128, cache-line width in bits
Q_WIDTH, 2, number of requesting queues; index Q_WIDTH-1 is the data queue and is the only one carrying line data
BANK_GAP, 2, idle cycles enforced after each response handoff (0 allowed)
TIMEOUT, 64, maximum WAIT cycles before the watchdog fires
CNT_W, 8, width of the gap and timeout counters (must hold TIMEOUT)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
addr_in  in  Q_WIDTH*32  per-queue head address, flattened; queue i at [i*32+:32]
data_in  in  CL_SIZE  head line data of queue Q_WIDTH-1
operation_in  in  Q_WIDTH*3  per-queue head operation
valid_in  in  Q_WIDTH  per-queue head valid
src_in  in  Q_WIDTH*2  per-queue source id
dest_in  in  Q_WIDTH*2  per-queue destination id
is_flush_in  in  Q_WIDTH  per-queue flush flag
dealloc  out  Q_WIDTH  one-hot pop pulse to the granted queue
bank_req_valid  out  1  one-cycle command strobe to dram_bank
bank_addr  out  32  latched address
bank_operation  out  3  latched operation
bank_data  out  CL_SIZE  latched data (zero unless granted queue is Q_WIDTH-1)
bank_rsp_valid  in  1  bank completion strobe
bank_rsp_data  in  CL_SIZE  bank response line
addr_out  out  32  response address
data_out  out  CL_SIZE  response line
operation_out  out  3  response operation
src_out  out  2  response source (= request dest)
dest_out  out  2  response destination (= request src)
is_flush_out  out  1  response flush flag
alloc_out  out  1  push strobe to output queue
full_in  in  1  output queue full
busy  out  1  state != IDLE
err_out  out  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP. Reset enters IDLE.
- Reset values: all outputs 0, including the latched request registers, round-robin pointer (ptr = 0) and err_out. Reset mid-operation abandons the transaction without popping further entries or pushing a response. A late bank_rsp_valid is ignored, because bank_rsp_valid is sampled only in WAIT.
- IDLE grant:
  - Grant goes to the first valid queue searching from ptr upward with wrap-around.
  - dealloc[g] is combinational and asserted in the same cycle (state==IDLE && any valid). At most one bit is ever set.
  - The request fields of g are latched at the clock edge; ptr becomes (g+1) mod Q_WIDTH; the FSM moves to ISSUE.
  - No valid input: remain in IDLE, dealloc = 0.
- ISSUE: bank_req_valid = 1 for exactly one cycle, then WAIT. The timeout counter clears to 0.
- WAIT:
  - On bank_rsp_valid: capture the response registers and go to RESP.
    - data_out = bank_rsp_data.
    - addr_out, operation_out and is_flush_out = latched request values.
    - src_out = latched dest; dest_out = latched src.
  - Otherwise increment the counter. When the counter reaches TIMEOUT-1 without a response: set err_out, build the response with data_out = 0, and go to RESP.
- RESP:
  - alloc_out = (state==RESP) && !full_in, combinational.
  - When alloc_out is 1: go to GAP (BANK_GAP>0, gap counter loaded with BANK_GAP-1) or to IDLE (BANK_GAP==0).
  - While full_in is 1: hold all response fields stable, alloc_out = 0, no bound on the wait.
- GAP: decrement the counter; at 0, go to IDLE. No grants are issued in GAP.
- Throughput: with BANK_GAP=0, a bank latency of L, and no backpressure, one request completes every L+3 cycles.
- Simultaneous events:
  - A valid rising on a queue during a non-IDLE state is not granted until IDLE.
  - full_in deasserting in the same cycle the FSM enters RESP gives alloc_out in that cycle.

Decomposition:
- Shared package mem_pkg holds:
  - the FSM state enum;
  - op encodings (OP_LD=3'd0, OP_ST=3'd1, OP_FLUSH=3'd2);
  - source/destination id constants.
- One sub-module: rr_arbiter (Q_WIDTH) taking valid and ptr, producing a one-hot grant and its index.

Test Plan:
- Single load on queue 0, addr 0x0000_1040, bank responds 3 cycles after the strobe → dealloc=2'b01 at T, bank_req_valid at T+1, alloc_out at T+5 with data_out = bank data and src/dest swapped.
- Both queues valid continuously, 4 requests → grants alternate 0,1,0,1. bank_data is zero for queue 0 grants and equals data_in for queue 1 grants.
- full_in held high 10 cycles in RESP → alloc_out stays 0 and fields stay stable; alloc_out pulses for 1 cycle the cycle full_in drops.
- Bank never responds, TIMEOUT=64 → err_out=1 after 64 WAIT cycles, a response with data 0 is pushed, and err_out stays 1 until rst.
- BANK_GAP=2 with back-to-back requests → exactly 2 cycles with dealloc=0 and busy=1 between alloc_out and the next grant.
- rst asserted during WAIT, then bank_rsp_valid arrives → all outputs 0, no alloc_out, next request is granted from ptr=0.
